// File: rtl/blink_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : blink_pkg
//  Brief   : Shared timing defaults, rate classes and detector FSM encoding
//            for the blink clock divider and its receive-side checker.
//  Rev     : 1.0  initial release
// ============================================================================
package blink_pkg;

    // Nominal half-periods in 50 MHz cycles (divider toggles at cnt==N-1)
    localparam int SLOW_HALF_DEF = 25_000_001;
    localparam int FAST_HALF_DEF = 12_500_001;
    localparam int TOL_DEF       = 1000;
    localparam int TIMEOUT_DEF   = 50_000_000;

    // Classification of one measured half-period
    typedef enum logic [1:0] {
        RATE_BAD  = 2'd0,
        RATE_SLOW = 2'd1,
        RATE_FAST = 2'd2
    } rate_e;

    // Detector state machine
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_TRACK = 2'd2,
        ST_LOCK  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module  : sync_edge_det
//  Brief   : Two-flop synchroniser for an asynchronous level plus a third
//            flop; emits a one-cycle pulse on either edge of the input.
//  Rev     : 1.0  initial release
// ============================================================================
module sync_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_in,
    output logic edge_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Synchroniser chain; s1 may go metastable, s2/s3 are clean
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_o = s2_q ^ s3_q;

endmodule
`default_nettype wire

// File: rtl/blink_rate_detector.sv
`default_nettype none
// ============================================================================
//  Module  : blink_rate_detector
//  Brief   : Measures the half-period of the blink square wave, classifies it
//            as SLOW / FAST / invalid, locks after two agreeing half-periods
//            and flags loss of signal.
//  Rev     : 1.0  initial release
// ============================================================================
module blink_rate_detector
    import blink_pkg::*;
#(
    parameter int CNT_W     = 28,
    parameter int SLOW_HALF = SLOW_HALF_DEF,
    parameter int FAST_HALF = FAST_HALF_DEF,
    parameter int TOL       = TOL_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] half_period,
    output logic             meas_stb,
    output logic             rate_valid,
    output logic             is_slow,
    output logic             is_fast,
    output logic             no_signal
);

    // One extra bit so |m - nominal| never wraps
    localparam logic [CNT_W:0] C_SLOW    = (CNT_W+1)'(SLOW_HALF);
    localparam logic [CNT_W:0] C_FAST    = (CNT_W+1)'(FAST_HALF);
    localparam logic [CNT_W:0] C_TOL     = (CNT_W+1)'(TOL);
    localparam logic [CNT_W:0] C_TIMEOUT = (CNT_W+1)'(TIMEOUT);

    logic             edge_det;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [CNT_W:0]   m_ext, diff_slow, diff_fast;
    logic             timeout_hit;
    rate_e            meas_class;

    state_e           state_d, state_q;
    rate_e            class_d, class_q;
    logic [CNT_W-1:0] half_period_d, half_period_q;
    logic             meas_stb_d, meas_stb_q;
    logic             rate_valid_d, rate_valid_q;
    logic             is_slow_d, is_slow_q;
    logic             is_fast_d, is_fast_q;
    logic             no_signal_d, no_signal_q;

    sync_edge_det u_sync_edge_det (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_in  (sig_in),
        .edge_o  (edge_det)
    );

    // Half-period counter: restarts at 1 on each edge, saturates instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (edge_det) begin
            cnt_d = CNT_W'(1);
        end else if (!(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Classify the current count; only acted upon on an edge cycle
    always_comb begin
        m_ext       = {1'b0, cnt_q};
        diff_slow   = (m_ext >= C_SLOW) ? (m_ext - C_SLOW) : (C_SLOW - m_ext);
        diff_fast   = (m_ext >= C_FAST) ? (m_ext - C_FAST) : (C_FAST - m_ext);
        timeout_hit = (m_ext >= C_TIMEOUT);
        if (diff_slow <= C_TOL) begin
            meas_class = RATE_SLOW;
        end else if (diff_fast <= C_TOL) begin
            meas_class = RATE_FAST;
        end else begin
            meas_class = RATE_BAD;
        end
    end

    // Lock state machine; an edge takes priority over a coincident timeout
    always_comb begin
        state_d       = state_q;
        class_d       = class_q;
        half_period_d = half_period_q;
        meas_stb_d    = 1'b0;
        rate_valid_d  = rate_valid_q;
        is_slow_d     = is_slow_q;
        is_fast_d     = is_fast_q;
        no_signal_d   = no_signal_q;

        if (state_q == ST_IDLE) begin
            // First edge only gives a reference point; the partial period is discarded
            if (edge_det) begin
                state_d = ST_FIRST;
            end
        end else if (edge_det) begin
            half_period_d = cnt_q;
            meas_stb_d    = 1'b1;
            no_signal_d   = 1'b0;
            case (state_q)
                ST_FIRST: begin
                    if (meas_class != RATE_BAD) begin
                        state_d = ST_TRACK;
                        class_d = meas_class;
                    end
                end
                ST_TRACK: begin
                    if (meas_class != RATE_BAD && meas_class == class_q) begin
                        state_d      = ST_LOCK;
                        rate_valid_d = 1'b1;
                        is_slow_d    = (meas_class == RATE_SLOW);
                        is_fast_d    = (meas_class == RATE_FAST);
                    end else if (meas_class != RATE_BAD) begin
                        class_d = meas_class;
                    end else begin
                        state_d = ST_FIRST;
                    end
                end
                default: begin  // ST_LOCK
                    if (meas_class != class_q) begin
                        rate_valid_d = 1'b0;
                        is_slow_d    = 1'b0;
                        is_fast_d    = 1'b0;
                        if (meas_class != RATE_BAD) begin
                            state_d = ST_TRACK;
                            class_d = meas_class;
                        end else begin
                            state_d = ST_FIRST;
                        end
                    end
                end
            endcase
        end else if (timeout_hit) begin
            state_d      = ST_IDLE;
            no_signal_d  = 1'b1;
            rate_valid_d = 1'b0;
            is_slow_d    = 1'b0;
            is_fast_d    = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q         <= '0;
            state_q       <= ST_IDLE;
            class_q       <= RATE_BAD;
            half_period_q <= '0;
            meas_stb_q    <= 1'b0;
            rate_valid_q  <= 1'b0;
            is_slow_q     <= 1'b0;
            is_fast_q     <= 1'b0;
            no_signal_q   <= 1'b1;
        end else begin
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            class_q       <= class_d;
            half_period_q <= half_period_d;
            meas_stb_q    <= meas_stb_d;
            rate_valid_q  <= rate_valid_d;
            is_slow_q     <= is_slow_d;
            is_fast_q     <= is_fast_d;
            no_signal_q   <= no_signal_d;
        end
    end

    assign half_period = half_period_q;
    assign meas_stb    = meas_stb_q;
    assign rate_valid  = rate_valid_q;
    assign is_slow     = is_slow_q;
    assign is_fast     = is_fast_q;
    assign no_signal   = no_signal_q;

endmodule
`default_nettype wire

// File: tb/tb_blink_rate_detector.sv
`default_nettype none
// ============================================================================
//  Module  : tb_blink_rate_detector
//  Brief   : Directed self-checking bench for blink_rate_detector using
//            scaled-down timing (SLOW 51, FAST 26, TOL 2, TIMEOUT 120).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_blink_rate_detector;

    localparam int CNT_W = 8;

    logic             clk;
    logic             reset_n;
    logic             sig_in;
    logic [CNT_W-1:0] half_period;
    logic             meas_stb;
    logic             rate_valid;
    logic             is_slow;
    logic             is_fast;
    logic             no_signal;

    int n_cmp;
    int n_bad;

    blink_rate_detector #(
        .CNT_W     (CNT_W),
        .SLOW_HALF (51),
        .FAST_HALF (26),
        .TOL       (2),
        .TIMEOUT   (120)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sig_in      (sig_in),
        .half_period (half_period),
        .meas_stb    (meas_stb),
        .rate_valid  (rate_valid),
        .is_slow     (is_slow),
        .is_fast     (is_fast),
        .no_signal   (no_signal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Toggle sig_in 'gap' cycles after the previous toggle, then sample the
    // outputs 1 time unit after the clock edge at which the edge registers
    // (3 cycles after the toggle).
    task automatic tog(input int gap);
        repeat (gap - 3) @(posedge clk);
        #1 sig_in = ~sig_in;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        sig_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (half_period !== 8'd0) begin n_bad++; $display("FAIL rst_hp: got %0d expected 0", half_period); end
        n_cmp++; if ({meas_stb, rate_valid, is_slow, is_fast} !== 4'b0000) begin n_bad++; $display("FAIL rst_flags: got %b expected 0000", {meas_stb, rate_valid, is_slow, is_fast}); end
        n_cmp++; if (no_signal !== 1'b1) begin n_bad++; $display("FAIL rst_nosig: got %b expected 1", no_signal); end
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_slow_lock;
        tog(20);
        n_cmp++; if (meas_stb !== 1'b0) begin n_bad++; $display("FAIL slow_e1_stb: got %b expected 0", meas_stb); end
        n_cmp++; if (no_signal !== 1'b1) begin n_bad++; $display("FAIL slow_e1_nosig: got %b expected 1", no_signal); end
        tog(51);
        n_cmp++; if (meas_stb !== 1'b1) begin n_bad++; $display("FAIL slow_e2_stb: got %b expected 1", meas_stb); end
        n_cmp++; if (half_period !== 8'd51) begin n_bad++; $display("FAIL slow_e2_hp: got %0d expected 51", half_period); end
        n_cmp++; if ({no_signal, rate_valid} !== 2'b00) begin n_bad++; $display("FAIL slow_e2_nosig_rv: got %b expected 00", {no_signal, rate_valid}); end
        tog(51);
        n_cmp++; if ({meas_stb, rate_valid, is_slow, is_fast} !== 4'b1110) begin n_bad++; $display("FAIL slow_lock: got %b expected 1110", {meas_stb, rate_valid, is_slow, is_fast}); end
        @(posedge clk);
        #1;
        n_cmp++; if (meas_stb !== 1'b0) begin n_bad++; $display("FAIL slow_stb_width: got %b expected 0", meas_stb); end
        tog(50);
        n_cmp++; if ({meas_stb, rate_valid, is_slow} !== 3'b111 || half_period !== 8'd51) begin n_bad++; $display("FAIL slow_hold: got stb/rv/slow %b hp %0d expected 111 hp 51", {meas_stb, rate_valid, is_slow}, half_period); end
    endtask

    task automatic test_loss;
        repeat (119) @(posedge clk);
        #1;
        n_cmp++; if ({no_signal, rate_valid} !== 2'b01) begin n_bad++; $display("FAIL loss_before: got nosig/rv %b expected 01", {no_signal, rate_valid}); end
        @(posedge clk);
        #1;
        n_cmp++; if ({no_signal, rate_valid, is_slow, is_fast} !== 4'b1000) begin n_bad++; $display("FAIL loss_flags: got %b expected 1000", {no_signal, rate_valid, is_slow, is_fast}); end
        n_cmp++; if (half_period !== 8'd51) begin n_bad++; $display("FAIL loss_hp: got %0d expected 51", half_period); end
    endtask

    task automatic test_fast_jitter;
        tog(30);
        n_cmp++; if ({meas_stb, no_signal} !== 2'b01) begin n_bad++; $display("FAIL fast_idle_edge: got stb/nosig %b expected 01", {meas_stb, no_signal}); end
        tog(26);
        n_cmp++; if ({meas_stb, rate_valid, no_signal} !== 3'b100 || half_period !== 8'd26) begin n_bad++; $display("FAIL fast_e2: got stb/rv/nosig %b hp %0d expected 100 hp 26", {meas_stb, rate_valid, no_signal}, half_period); end
        tog(27);
        n_cmp++; if ({rate_valid, is_slow, is_fast} !== 3'b101 || half_period !== 8'd27) begin n_bad++; $display("FAIL fast_lock: got rv/slow/fast %b hp %0d expected 101 hp 27", {rate_valid, is_slow, is_fast}, half_period); end
        tog(25);
        n_cmp++; if ({meas_stb, rate_valid, is_fast} !== 3'b111 || half_period !== 8'd25) begin n_bad++; $display("FAIL fast_j25: got stb/rv/fast %b hp %0d expected 111 hp 25", {meas_stb, rate_valid, is_fast}, half_period); end
        tog(26);
        n_cmp++; if ({rate_valid, is_fast} !== 2'b11 || half_period !== 8'd26) begin n_bad++; $display("FAIL fast_j26: got rv/fast %b hp %0d expected 11 hp 26", {rate_valid, is_fast}, half_period); end
    endtask

    task automatic test_rate_switch;
        tog(51);
        n_cmp++; if ({meas_stb, rate_valid, is_fast} !== 3'b100 || half_period !== 8'd51) begin n_bad++; $display("FAIL sw_to_slow_drop: got stb/rv/fast %b hp %0d expected 100 hp 51", {meas_stb, rate_valid, is_fast}, half_period); end
        tog(51);
        n_cmp++; if ({rate_valid, is_slow, is_fast} !== 3'b110) begin n_bad++; $display("FAIL sw_slow_lock: got %b expected 110", {rate_valid, is_slow, is_fast}); end
        tog(26);
        n_cmp++; if ({meas_stb, rate_valid, is_slow, is_fast} !== 4'b1000) begin n_bad++; $display("FAIL sw_to_fast_drop: got %b expected 1000", {meas_stb, rate_valid, is_slow, is_fast}); end
        tog(26);
        n_cmp++; if ({rate_valid, is_slow, is_fast} !== 3'b101) begin n_bad++; $display("FAIL sw_fast_lock: got %b expected 101", {rate_valid, is_slow, is_fast}); end
    endtask

    task automatic test_bad_period;
        tog(51);
        tog(51);
        n_cmp++; if ({rate_valid, is_slow} !== 2'b11) begin n_bad++; $display("FAIL bad_prelock: got %b expected 11", {rate_valid, is_slow}); end
        tog(40);
        n_cmp++; if ({meas_stb, rate_valid, is_slow} !== 3'b100 || half_period !== 8'd40) begin n_bad++; $display("FAIL bad_40: got stb/rv/slow %b hp %0d expected 100 hp 40", {meas_stb, rate_valid, is_slow}, half_period); end
        tog(51);
        n_cmp++; if (rate_valid !== 1'b0) begin n_bad++; $display("FAIL bad_relock1: got %b expected 0", rate_valid); end
        tog(51);
        n_cmp++; if ({rate_valid, is_slow} !== 2'b11) begin n_bad++; $display("FAIL bad_relock2: got %b expected 11", {rate_valid, is_slow}); end
        tog(53);
        n_cmp++; if (rate_valid !== 1'b1 || half_period !== 8'd53) begin n_bad++; $display("FAIL bad_tol_edge53: got rv %b hp %0d expected 1 hp 53", rate_valid, half_period); end
        tog(54);
        n_cmp++; if ({meas_stb, rate_valid} !== 2'b10) begin n_bad++; $display("FAIL bad_tol_out54: got stb/rv %b expected 10", {meas_stb, rate_valid}); end
        tog(49);
        tog(49);
        n_cmp++; if ({rate_valid, is_slow} !== 2'b11 || half_period !== 8'd49) begin n_bad++; $display("FAIL bad_tol_edge49: got rv/slow %b hp %0d expected 11 hp 49", {rate_valid, is_slow}, half_period); end
    endtask

    task automatic test_reset_mid;
        repeat (20) @(posedge clk);
        #1 reset_n = 1'b0;
        sig_in = 1'b0;
        #2;
        n_cmp++; if ({rate_valid, is_slow, is_fast, meas_stb, no_signal} !== 5'b00001) begin n_bad++; $display("FAIL rmid_async: got %b expected 00001", {rate_valid, is_slow, is_fast, meas_stb, no_signal}); end
        n_cmp++; if (half_period !== 8'd0) begin n_bad++; $display("FAIL rmid_hp: got %0d expected 0", half_period); end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tog(10);
        n_cmp++; if ({meas_stb, no_signal} !== 2'b01) begin n_bad++; $display("FAIL rmid_first_edge: got stb/nosig %b expected 01", {meas_stb, no_signal}); end
        tog(51);
        n_cmp++; if ({meas_stb, no_signal} !== 2'b10 || half_period !== 8'd51) begin n_bad++; $display("FAIL rmid_second_edge: got stb/nosig %b hp %0d expected 10 hp 51", {meas_stb, no_signal}, half_period); end
    endtask

    task automatic test_edge_vs_timeout;
        tog(120);
        n_cmp++; if ({meas_stb, no_signal, rate_valid} !== 3'b100 || half_period !== 8'd120) begin n_bad++; $display("FAIL evt_edge_wins: got stb/nosig/rv %b hp %0d expected 100 hp 120", {meas_stb, no_signal, rate_valid}, half_period); end
        tog(121);
        n_cmp++; if ({meas_stb, no_signal} !== 2'b01 || half_period !== 8'd120) begin n_bad++; $display("FAIL evt_timeout_first: got stb/nosig %b hp %0d expected 01 hp 120", {meas_stb, no_signal}, half_period); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_slow_lock();
        test_loss();
        test_fast_jitter();
        test_rate_switch();
        test_bad_period();
        test_reset_mid();
        test_edge_vs_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
